// File: rtl/priority_decoder_seq.sv
// Sequential binary-to-one-hot decoder: accepts a code via valid/ready, holds the
// decoded line for HOLD cycles, then idles for GAP cycles before accepting again.
module priority_decoder_seq #(
    parameter int unsigned CODE_W = 2,
    parameter int unsigned HOLD   = 3,
    parameter int unsigned GAP    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CODE_W-1:0]        code,
    input  logic                     code_valid,
    output logic                     code_ready,
    input  logic                     abort,
    output logic [(2**CODE_W)-1:0]   onehot_out,
    output logic                     out_active,
    output logic                     busy,
    output logic [7:0]               accept_cnt
);

    localparam int unsigned OUT_W    = 2 ** CODE_W;
    localparam int unsigned HoldEff  = (HOLD == 0) ? 1 : HOLD;
    localparam logic [7:0]  HoldLoad = 8'(HoldEff - 1);
    localparam logic [7:0]  GapLoad  = 8'((GAP == 0) ? 0 : GAP - 1);
    localparam bit          NoGap    = (GAP == 0);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]   onehot_q, onehot_d;
    logic [7:0]         acc_q, acc_d;
    logic               accept;
    logic               last_hold;

    // With no guard gap the final hold cycle also accepts, so codes run back to back.
    assign last_hold  = NoGap && (state_q == StHold) && (cnt_q == 8'd0);
    assign code_ready = !abort && ((state_q == StIdle) || last_hold);
    assign accept     = code_valid && code_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        acc_d    = acc_q;

        unique case (state_q)
            StIdle: begin
                onehot_d = '0;
            end
            StHold: begin
                if (abort) begin
                    state_d  = StIdle;
                    cnt_d    = 8'd0;
                    onehot_d = '0;
                end else if (cnt_q == 8'd0) begin
                    onehot_d = '0;
                    if (NoGap) begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StGap: begin
                onehot_d = '0;
                if (abort || (cnt_q == 8'd0)) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = 8'd0;
                onehot_d = '0;
            end
        endcase

        if (accept) begin
            state_d  = StHold;
            cnt_d    = HoldLoad;
            onehot_d = OUT_W'(1) << code;
            acc_d    = acc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            onehot_q <= '0;
            acc_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            acc_q    <= acc_d;
        end
    end

    assign onehot_out = onehot_q;
    assign out_active = |onehot_q;
    assign busy       = (state_q != StIdle);
    assign accept_cnt = acc_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq with HOLD=3, GAP=1, CODE_W=2.
module tb_priority_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       abort;
    logic [3:0] onehot_out;
    logic       out_active;
    logic       busy;
    logic [7:0] accept_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    priority_decoder_seq #(
        .CODE_W (2),
        .HOLD   (3),
        .GAP    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .abort      (abort),
        .onehot_out (onehot_out),
        .out_active (out_active),
        .busy       (busy),
        .accept_cnt (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!code_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!code_ready) check("ready_timeout", {31'd0, code_ready}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] c);
        wait_ready();
        code       = c;
        code_valid = 1'b1;
        cyc();
        code_valid = 1'b0;
    endtask

    // Full accept/hold/gap check: output held 3 cycles, then one zero gap cycle.
    task automatic decode_check(input string tag, input logic [1:0] c, input logic [3:0] exp);
        issue(c);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_hold"}, {28'd0, onehot_out}, {28'd0, exp});
            check({tag, "_act"}, {31'd0, out_active}, 32'd1);
            if (i < 2) cyc();
        end
        cyc();
        check({tag, "_gap"}, {28'd0, onehot_out}, 32'd0);
        check({tag, "_gap_rdy"}, {31'd0, code_ready}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        code       = 2'd0;
        code_valid = 1'b0;
        abort      = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;

        check("rst_onehot", {28'd0, onehot_out}, 32'd0);
        check("rst_active", {31'd0, out_active}, 32'd0);
        check("rst_ready", {31'd0, code_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {24'd0, accept_cnt}, 32'd0);

        // Single decode of code 2.
        code       = 2'd2;
        code_valid = 1'b1;
        cyc();
        code_valid = 1'b0;
        check("single_n1", {28'd0, onehot_out}, 32'h4);
        check("single_n1_rdy", {31'd0, code_ready}, 32'd0);
        check("single_n1_busy", {31'd0, busy}, 32'd1);
        cyc();
        check("single_n2", {28'd0, onehot_out}, 32'h4);
        cyc();
        check("single_n3", {28'd0, onehot_out}, 32'h4);
        cyc();
        check("single_n4", {28'd0, onehot_out}, 32'h0);
        check("single_n4_rdy", {31'd0, code_ready}, 32'd0);
        check("single_n4_busy", {31'd0, busy}, 32'd1);
        cyc();
        check("single_n5_rdy", {31'd0, code_ready}, 32'd1);
        check("single_n5_busy", {31'd0, busy}, 32'd0);
        check("single_cnt", {24'd0, accept_cnt}, 32'd1);

        // Sweep every code.
        decode_check("sweep0", 2'd0, 4'b0001);
        decode_check("sweep1", 2'd1, 4'b0010);
        decode_check("sweep2", 2'd2, 4'b0100);
        decode_check("sweep3", 2'd3, 4'b1000);
        cyc();
        check("sweep_cnt", {24'd0, accept_cnt}, 32'd5);

        // Valid held high while the code changes during HOLD.
        wait_ready();
        code       = 2'd3;
        code_valid = 1'b1;
        cyc();
        code = 2'd1;
        for (int i = 0; i < 3; i++) begin
            check("held_out", {28'd0, onehot_out}, 32'h8);
            cyc();
        end
        check("held_gap", {28'd0, onehot_out}, 32'h0);
        check("held_cnt_busy", {24'd0, accept_cnt}, 32'd6);
        cyc();
        check("held_rdy", {31'd0, code_ready}, 32'd1);
        cyc();
        code_valid = 1'b0;
        check("held_second", {28'd0, onehot_out}, 32'h2);
        check("held_cnt", {24'd0, accept_cnt}, 32'd7);

        // Abort in the second hold cycle of code 3.
        issue(2'd3);
        check("abort_h1", {28'd0, onehot_out}, 32'h8);
        cyc();
        abort = 1'b1;
        check("abort_h2", {28'd0, onehot_out}, 32'h8);
        cyc();
        abort = 1'b0;
        check("abort_out", {28'd0, onehot_out}, 32'h0);
        check("abort_act", {31'd0, out_active}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cnt", {24'd0, accept_cnt}, 32'd8);

        // Abort in IDLE masks a simultaneous valid.
        abort      = 1'b1;
        code       = 2'd2;
        code_valid = 1'b1;
        #1;
        check("idle_abort_rdy", {31'd0, code_ready}, 32'd0);
        cyc();
        abort      = 1'b0;
        code_valid = 1'b0;
        check("idle_abort_out", {28'd0, onehot_out}, 32'h0);
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_cnt", {24'd0, accept_cnt}, 32'd8);

        // Reset during HOLD.
        issue(2'd1);
        check("rst_mid_pre", {28'd0, onehot_out}, 32'h2);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rst_mid_out", {28'd0, onehot_out}, 32'h0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cnt", {24'd0, accept_cnt}, 32'd0);
        check("rst_mid_rdy", {31'd0, code_ready}, 32'd1);

        // Counter wrap after 256 accepts.
        for (int i = 0; i < 255; i++) issue(2'(i));
        check("wrap_255", {24'd0, accept_cnt}, 32'd255);
        issue(2'd0);
        check("wrap_0", {24'd0, accept_cnt}, 32'd0);
        check("wrap_out", {28'd0, onehot_out}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
